// File: rtl/sdt_pkg.sv
// sdt_pkg: shared types and constants for the single data transfer unit.
//   REG_W / DATA_W / OFF_W : register index, data and offset-field widths
//   SH_*                   : shift-type encodings of offset[6:5]
//   state_e                : sequencer states
//   instr_t                : instruction fields latched when a transfer starts
// Optional feature macro: SDT_REG_OFFSET_EN (register-offset addressing).
package sdt_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 32;
    localparam int OFF_W  = 12;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_BASE  = 4'd1,
        ST_RD_OFF   = 4'd2,
        ST_CALC     = 4'd3,
        ST_RD_DATA  = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WAIT = 4'd7,
        ST_WB       = 4'd8,
        ST_WR_RD    = 4'd9
    } state_e;

    typedef struct packed {
        logic             imm;
        logic             pre;
        logic             up;
        logic             word;
        logic             wr;
        logic             load;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rd;
        logic [OFF_W-1:0] off;
    } instr_t;

endpackage

// File: rtl/sdt_shifter.sv
// sdt_shifter: combinational barrel shift of the offset register Rm.
//   rm      in  DATA_W  value to shift
//   sh_type in  2       SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   sh_amt  in  5       shift amount; 0 returns rm unchanged for every type
//   result  out DATA_W  shifted value
module sdt_shifter
    import sdt_pkg::*;
(
    input  logic [DATA_W-1:0] rm,
    input  logic [1:0]        sh_type,
    input  logic [4:0]        sh_amt,
    output logic [DATA_W-1:0] result
);

    logic [5:0] inv_amt;

    // Left-shift amount for the rotate; for sh_amt=0 it is 32, which shifts
    // everything out and leaves the plain right shift (i.e. rm).
    assign inv_amt = 6'd32 - {1'b0, sh_amt};

    always_comb begin
        result = rm;
        unique case (sh_type)
            SH_LSL:  result = rm << sh_amt;
            SH_LSR:  result = rm >> sh_amt;
            SH_ASR:  result = $unsigned($signed(rm) >>> sh_amt);
            SH_ROR:  result = (rm >> sh_amt) | (rm << inv_amt);
            default: result = rm;
        endcase
    end

endmodule

// File: rtl/sdt_unit.sv
// sdt_unit: single data transfer (LDR/STR/LDRB/STRB) sequencer.
// Reads base (and optionally an offset register), forms the address, performs
// one memory access, then writes back the base and/or the loaded value.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   en + instruction fields     start request, sampled only when idle
//   read_en/read_reg/read_value register-file read (data one cycle later)
//   write_en/write_reg/...      register-file write
//   data_{read,write}_{word,byte}_*  memory port (read data one cycle later)
// Optional feature: define SDT_REG_OFFSET_EN for register offsets (Rm shifted
// by offset[11:7] per offset[6:5]) selected by immediate=0.
// Timing: reads and memory reads are visible in the cycle of their state;
// memory writes and register writes are loaded as their state is left (store
// data only arrives during MEM_WR), so they appear one cycle later.
module sdt_unit
    import sdt_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                immediate,
    input  logic                pre,
    input  logic                up,
    input  logic                word,
    input  logic                write,
    input  logic                load,
    input  logic [REG_W-1:0]    rn,
    input  logic [REG_W-1:0]    rd,
    input  logic [OFF_W-1:0]    offset,
    output logic                write_en,
    output logic [REG_W-1:0]    write_reg,
    output logic [DATA_W-1:0]   write_value,
    output logic                write_restore_from_SPSR,
    output logic                read_en,
    output logic [REG_W-1:0]    read_reg,
    input  logic [DATA_W-1:0]   read_value,
    output logic                data_write_word_en,
    output logic                data_write_byte_en,
    output logic                data_read_word_en,
    output logic                data_read_byte_en,
    output logic [DATA_W-1:0]   data_write_word_address,
    output logic [DATA_W-1:0]   data_write_byte_address,
    output logic [DATA_W-1:0]   data_read_word_address,
    output logic [DATA_W-1:0]   data_read_byte_address,
    output logic [DATA_W-1:0]   data_write_word_data,
    output logic [7:0]          data_write_byte_data,
    input  logic [DATA_W-1:0]   data_read_word_data,
    input  logic [7:0]          data_read_byte_data
);

    state_e              state_q, state_d;
    instr_t              cur_q, cur_d;
    logic [DATA_W-1:0]   eff_q, eff_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   ldata_q, ldata_d;

    logic                write_en_q, write_en_d;
    logic [REG_W-1:0]    write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_value_q, write_value_d;
    logic                read_en_q, read_en_d;
    logic [REG_W-1:0]    read_reg_q, read_reg_d;
    logic                dww_en_q, dww_en_d, dwb_en_q, dwb_en_d;
    logic                drw_en_q, drw_en_d, drb_en_q, drb_en_d;
    logic [DATA_W-1:0]   dww_addr_q, dww_addr_d, dwb_addr_q, dwb_addr_d;
    logic [DATA_W-1:0]   drw_addr_q, drw_addr_d, drb_addr_q, drb_addr_d;
    logic [DATA_W-1:0]   dww_data_q, dww_data_d;
    logic [7:0]          dwb_data_q, dwb_data_d;

    logic [DATA_W-1:0]   base_val, off_val, eff_calc, acc_addr;
    logic                reg_path;

`ifdef SDT_REG_OFFSET_EN
    logic [DATA_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   shift_res;

    sdt_shifter u_shifter (
        .rm      (read_value),
        .sh_type (cur_q.off[6:5]),
        .sh_amt  (cur_q.off[11:7]),
        .result  (shift_res)
    );

    // On the register path base was captured in RD_OFF and read_value now
    // carries Rm; on the immediate path read_value still carries the base.
    assign reg_path = ~cur_q.imm;
    assign base_val = reg_path ? base_q : read_value;
    assign off_val  = reg_path ? shift_res : {{(DATA_W-OFF_W){1'b0}}, cur_q.off};
`else
    logic unused_imm;
    assign unused_imm = cur_q.imm;
    assign reg_path   = 1'b0;
    assign base_val   = read_value;
    assign off_val    = {{(DATA_W-OFF_W){1'b0}}, cur_q.off};
`endif

    assign eff_calc = cur_q.up ? (base_val + off_val) : (base_val - off_val);
    assign acc_addr = cur_q.pre ? eff_calc : base_val;

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        eff_d         = eff_q;
        addr_d        = addr_q;
        ldata_d       = ldata_q;
        write_en_d    = 1'b0;
        write_reg_d   = write_reg_q;
        write_value_d = write_value_q;
        read_en_d     = 1'b0;
        read_reg_d    = read_reg_q;
        dww_en_d      = 1'b0;
        dwb_en_d      = 1'b0;
        drw_en_d      = 1'b0;
        drb_en_d      = 1'b0;
        dww_addr_d    = dww_addr_q;
        dwb_addr_d    = dwb_addr_q;
        drw_addr_d    = drw_addr_q;
        drb_addr_d    = drb_addr_q;
        dww_data_d    = dww_data_q;
        dwb_data_d    = dwb_data_q;
`ifdef SDT_REG_OFFSET_EN
        base_d        = base_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    cur_d      = '{imm: immediate, pre: pre, up: up, word: word,
                                   wr: write, load: load, rn: rn, rd: rd, off: offset};
                    state_d    = ST_RD_BASE;
                    read_en_d  = 1'b1;
                    read_reg_d = rn;
                end
            end
            ST_RD_BASE: begin
                if (reg_path) begin
                    state_d    = ST_RD_OFF;
                    read_en_d  = 1'b1;
                    read_reg_d = cur_q.off[REG_W-1:0];
                end else begin
                    state_d    = ST_CALC;
                end
            end
            ST_RD_OFF: begin
`ifdef SDT_REG_OFFSET_EN
                base_d  = read_value;
`endif
                state_d = ST_CALC;
            end
            ST_CALC: begin
                eff_d  = eff_calc;
                addr_d = acc_addr;
                if (cur_q.load) begin
                    state_d = ST_MEM_RD;
                    if (cur_q.word) begin
                        drw_en_d   = 1'b1;
                        drw_addr_d = acc_addr;
                    end else begin
                        drb_en_d   = 1'b1;
                        drb_addr_d = acc_addr;
                    end
                end else begin
                    state_d    = ST_RD_DATA;
                    read_en_d  = 1'b1;
                    read_reg_d = cur_q.rd;
                end
            end
            ST_RD_DATA: state_d = ST_MEM_WR;
            ST_MEM_WR: begin
                // Rd is on read_value now; the write pulse lands next cycle.
                if (cur_q.word) begin
                    dww_en_d   = 1'b1;
                    dww_addr_d = addr_q;
                    dww_data_d = read_value;
                end else begin
                    dwb_en_d   = 1'b1;
                    dwb_addr_d = addr_q;
                    dwb_data_d = read_value[7:0];
                end
                state_d = ST_WB;
            end
            ST_MEM_RD: state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                ldata_d = cur_q.word ? data_read_word_data
                                     : {{(DATA_W-8){1'b0}}, data_read_byte_data};
                state_d = ST_WB;
            end
            ST_WB: begin
                // Post-indexed forms always write the base back.
                if (cur_q.wr || !cur_q.pre) begin
                    write_en_d    = 1'b1;
                    write_reg_d   = cur_q.rn;
                    write_value_d = eff_q;
                end
                state_d = cur_q.load ? ST_WR_RD : ST_IDLE;
            end
            ST_WR_RD: begin
                // Issued after the base write so Rd wins when rn == rd.
                write_en_d    = 1'b1;
                write_reg_d   = cur_q.rd;
                write_value_d = ldata_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            eff_q         <= '0;
            addr_q        <= '0;
            ldata_q       <= '0;
            write_en_q    <= 1'b0;
            write_reg_q   <= '0;
            write_value_q <= '0;
            read_en_q     <= 1'b0;
            read_reg_q    <= '0;
            dww_en_q      <= 1'b0;
            dwb_en_q      <= 1'b0;
            drw_en_q      <= 1'b0;
            drb_en_q      <= 1'b0;
            dww_addr_q    <= '0;
            dwb_addr_q    <= '0;
            drw_addr_q    <= '0;
            drb_addr_q    <= '0;
            dww_data_q    <= '0;
            dwb_data_q    <= '0;
`ifdef SDT_REG_OFFSET_EN
            base_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            eff_q         <= eff_d;
            addr_q        <= addr_d;
            ldata_q       <= ldata_d;
            write_en_q    <= write_en_d;
            write_reg_q   <= write_reg_d;
            write_value_q <= write_value_d;
            read_en_q     <= read_en_d;
            read_reg_q    <= read_reg_d;
            dww_en_q      <= dww_en_d;
            dwb_en_q      <= dwb_en_d;
            drw_en_q      <= drw_en_d;
            drb_en_q      <= drb_en_d;
            dww_addr_q    <= dww_addr_d;
            dwb_addr_q    <= dwb_addr_d;
            drw_addr_q    <= drw_addr_d;
            drb_addr_q    <= drb_addr_d;
            dww_data_q    <= dww_data_d;
            dwb_data_q    <= dwb_data_d;
`ifdef SDT_REG_OFFSET_EN
            base_q        <= base_d;
`endif
        end
    end

    assign write_en                = write_en_q;
    assign write_reg               = write_reg_q;
    assign write_value             = write_value_q;
    assign write_restore_from_SPSR = 1'b0;
    assign read_en                 = read_en_q;
    assign read_reg                = read_reg_q;
    assign data_write_word_en      = dww_en_q;
    assign data_write_byte_en      = dwb_en_q;
    assign data_read_word_en       = drw_en_q;
    assign data_read_byte_en       = drb_en_q;
    assign data_write_word_address = dww_addr_q;
    assign data_write_byte_address = dwb_addr_q;
    assign data_read_word_address  = drw_addr_q;
    assign data_read_byte_address  = drb_addr_q;
    assign data_write_word_data    = dww_data_q;
    assign data_write_byte_data    = dwb_data_q;

endmodule

// File: tb/tb_sdt_unit.sv
// tb_sdt_unit: bench for sdt_unit with a register-file/memory environment,
// a directed vector table, a transaction-level reference model for random
// instructions, and hand-written reset-abort and held-enable sequences.
module tb_sdt_unit;

    typedef struct packed {
        logic imm, pre, up, word, wr, load;
        logic [3:0] rn, rd;
        logic [11:0] off;
    } ins_t;

    typedef struct {
        ins_t        ins;
        logic [31:0] exp_rn;    // Rn after the op
        logic [31:0] chk_addr;  // store: address to inspect
        logic [31:0] exp_val;   // load: Rd after; store: memory contents
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, immediate, pre, up, word, write, load;
    logic [3:0]  rn, rd;
    logic [11:0] offset;
    logic        write_en, write_restore_from_SPSR, read_en;
    logic [3:0]  write_reg, read_reg;
    logic [31:0] write_value, read_value;
    logic        data_write_word_en, data_write_byte_en, data_read_word_en, data_read_byte_en;
    logic [31:0] data_write_word_address, data_write_byte_address;
    logic [31:0] data_read_word_address, data_read_byte_address;
    logic [31:0] data_write_word_data, data_read_word_data;
    logic [7:0]  data_write_byte_data, data_read_byte_data;

    sdt_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .immediate(immediate), .pre(pre), .up(up),
        .word(word), .write(write), .load(load), .rn(rn), .rd(rd), .offset(offset),
        .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
        .write_restore_from_SPSR(write_restore_from_SPSR),
        .read_en(read_en), .read_reg(read_reg), .read_value(read_value),
        .data_write_word_en(data_write_word_en), .data_write_byte_en(data_write_byte_en),
        .data_read_word_en(data_read_word_en), .data_read_byte_en(data_read_byte_en),
        .data_write_word_address(data_write_word_address),
        .data_write_byte_address(data_write_byte_address),
        .data_read_word_address(data_read_word_address),
        .data_read_byte_address(data_read_byte_address),
        .data_write_word_data(data_write_word_data),
        .data_write_byte_data(data_write_byte_data),
        .data_read_word_data(data_read_word_data),
        .data_read_byte_data(data_read_byte_data)
    );

    // ---------------- environment: register file + byte memory ----------------
    logic [31:0] regs [16];
    logic [7:0]  mem [logic [31:0]];
    logic        poke_en;
    logic [3:0]  poke_idx;
    logic [31:0] poke_val;

    function automatic logic [7:0] env_rd8(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction
    function automatic logic [31:0] env_rd32(input logic [31:0] a);
        return {env_rd8(a + 32'd3), env_rd8(a + 32'd2), env_rd8(a + 32'd1), env_rd8(a)};
    endfunction

    always @(posedge clk) begin
        if (poke_en)  regs[poke_idx]  <= poke_val;
        if (write_en) regs[write_reg] <= write_value;
        if (read_en)  read_value      <= regs[read_reg];
        if (data_read_word_en) data_read_word_data <= env_rd32(data_read_word_address);
        if (data_read_byte_en) data_read_byte_data <= env_rd8(data_read_byte_address);
        if (data_write_word_en)
            for (int k = 0; k < 4; k++)
                mem[data_write_word_address + 32'(k)] = data_write_word_data[8*k +: 8];
        if (data_write_byte_en) mem[data_write_byte_address] = data_write_byte_data;
    end

    // ---------------- pulse monitor ----------------
    int wen_cnt = 0, dwr_cnt = 0, drd_cnt = 0, viol_cnt = 0;
    always @(posedge clk) begin
        if (write_en) wen_cnt <= wen_cnt + 1;
        if (data_write_word_en || data_write_byte_en) dwr_cnt <= dwr_cnt + 1;
        if (data_read_word_en || data_read_byte_en)   drd_cnt <= drd_cnt + 1;
        if ($countones({write_en, read_en, data_write_word_en, data_write_byte_en,
                        data_read_word_en, data_read_byte_en}) > 1)
            viol_cnt <= viol_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_regs [16];
    logic [7:0]  exp_mem [logic [31:0]];

    function automatic logic [7:0] model_rd8(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 8'h00;
    endfunction
    function automatic logic [31:0] model_rd32(input logic [31:0] a);
        return {model_rd8(a + 32'd3), model_rd8(a + 32'd2), model_rd8(a + 32'd1), model_rd8(a)};
    endfunction

`ifdef SDT_REG_OFFSET_EN
    function automatic logic [31:0] model_shift(input logic [31:0] v, input logic [1:0] ty,
                                                input int amt);
        logic [31:0] r;
        r = v;
        case (ty)
            2'd0: r = v << amt;
            2'd1: r = v >> amt;
            2'd2: r = $unsigned($signed(v) >>> amt);
            default: for (int k = 0; k < amt; k++) r = {r[0], r[31:1]};
        endcase
        return r;
    endfunction
`endif

    task automatic model_exec(input ins_t i, output logic [31:0] addr);
        logic [31:0] base, off, eff, val;
        base = exp_regs[i.rn];
        off  = {20'd0, i.off};
`ifdef SDT_REG_OFFSET_EN
        if (!i.imm) off = model_shift(exp_regs[i.off[3:0]], i.off[6:5], int'(i.off[11:7]));
`endif
        eff  = i.up ? base + off : base - off;
        addr = i.pre ? eff : base;
        if (!i.load) begin
            val = exp_regs[i.rd];
            if (i.word) for (int k = 0; k < 4; k++) exp_mem[addr + 32'(k)] = val[8*k +: 8];
            else exp_mem[addr] = val[7:0];
        end else begin
            val = i.word ? model_rd32(addr) : {24'd0, model_rd8(addr)};
        end
        if (i.wr || !i.pre) exp_regs[i.rn] = eff;
        if (i.load) exp_regs[i.rd] = val;
    endtask

    // ---------------- helpers ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", nm, act, exp);
        end
    endtask

    function automatic logic outs_any();
        return |{write_en, write_reg, write_value, write_restore_from_SPSR, read_en, read_reg,
                 data_write_word_en, data_write_byte_en, data_read_word_en, data_read_byte_en,
                 data_write_word_address, data_write_byte_address, data_read_word_address,
                 data_read_byte_address, data_write_word_data, data_write_byte_data};
    endfunction

    function automatic ins_t mk(input logic i, p, u, w, b, l, input logic [3:0] n, d,
                                input logic [11:0] o);
        ins_t t;
        t = '{imm: i, pre: p, up: u, word: w, wr: b, load: l, rn: n, rd: d, off: o};
        return t;
    endfunction

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        exp_regs[idx] = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic drive(input ins_t t);
        immediate = t.imm; pre = t.pre; up = t.up; word = t.word;
        write = t.wr; load = t.load; rn = t.rn; rd = t.rd; offset = t.off;
    endtask

    // Every op must be finished well inside the 12-cycle window.
    task automatic run_op(input ins_t t);
        @(negedge clk);
        drive(t);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    vec_t vecs [10];

    initial begin
        logic [31:0] a;
        int w0, d0, r0;

        vecs[0] = '{mk(1,1,1,1,1,0, 4'd1,  4'd3,  12'd4), 32'h104, 32'h104,  32'hDEADBEEF};
        vecs[1] = '{mk(1,1,1,1,0,1, 4'd1,  4'd10, 12'd0), 32'h104, 32'h0,    32'hDEADBEEF};
        vecs[2] = '{mk(1,1,1,0,0,0, 4'd2,  4'd5,  12'd0), 32'h200, 32'h200,  32'h000000AA};
        vecs[3] = '{mk(1,1,1,0,0,1, 4'd2,  4'd11, 12'd0), 32'h200, 32'h0,    32'h000000AA};
        vecs[4] = '{mk(1,1,1,0,0,0, 4'd6,  4'd7,  12'd0), 32'h3000, 32'h3000, 32'h00000077};
        vecs[5] = '{mk(1,0,1,0,0,1, 4'd6,  4'd8,  12'd4), 32'h3004, 32'h0,   32'h00000077};
        vecs[6] = '{mk(1,1,0,1,1,0, 4'd1,  4'd3,  12'd4), 32'h100, 32'h100,  32'hDEADBEEF};
        vecs[7] = '{mk(1,1,1,1,1,1, 4'd1,  4'd1,  12'd4), 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[8] = '{mk(1,0,0,0,0,1, 4'd12, 4'd13, 12'd4), 32'hFFFFFFFE, 32'h0, 32'h00000000};
        vecs[9] = '{mk(1,1,1,1,0,0, 4'd6,  4'd3,  12'd1), 32'h3004, 32'h3005, 32'hDEADBEEF};

        rst_n = 1'b0; en = 1'b0; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        drive('0);
        repeat (3) @(negedge clk);
        chk("reset_outs_zero", {31'd0, outs_any()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs_zero", {31'd0, outs_any()}, 32'd0);

        for (int i = 0; i < 16; i++) poke(4'(i), 32'h0);
        poke(4'd1, 32'h100);  poke(4'd3, 32'hDEADBEEF);
        poke(4'd2, 32'h200);  poke(4'd5, 32'hAA);
        poke(4'd6, 32'h3000); poke(4'd7, 32'h77);
        poke(4'd12, 32'h2);   poke(4'd13, 32'h55);

        // directed table
        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].ins);
            model_exec(vecs[v].ins, a);
            chk($sformatf("vec%0d_rn", v), regs[vecs[v].ins.rn], vecs[v].exp_rn);
            if (vecs[v].ins.load)
                chk($sformatf("vec%0d_rd", v), regs[vecs[v].ins.rd], vecs[v].exp_val);
            else if (vecs[v].ins.word)
                chk($sformatf("vec%0d_mem", v), env_rd32(vecs[v].chk_addr), vecs[v].exp_val);
            else
                chk($sformatf("vec%0d_mem", v), {24'd0, env_rd8(vecs[v].chk_addr)}, vecs[v].exp_val);
        end

        // random instructions against the model
        for (int i = 0; i < 16; i++)
            poke(4'(i), (i < 8) ? 32'h4000 + $urandom_range(0, 255) : $urandom);
        for (int n = 0; n < 40; n++) begin
            ins_t t;
            t.imm  = 1'($urandom_range(0, 1));
            t.pre  = 1'($urandom_range(0, 1));
            t.up   = 1'($urandom_range(0, 1));
            t.word = 1'($urandom_range(0, 1));
            t.wr   = 1'($urandom_range(0, 1));
            t.load = 1'($urandom_range(0, 1));
            t.rn   = 4'($urandom_range(0, 7));
            t.rd   = 4'($urandom_range(0, 15));
            t.off  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
            run_op(t);
            model_exec(t, a);
            chk($sformatf("rand%0d_rn", n), regs[t.rn], exp_regs[t.rn]);
            chk($sformatf("rand%0d_rd", n), regs[t.rd], exp_regs[t.rd]);
            if (!t.load) chk($sformatf("rand%0d_mem", n), env_rd32(a), model_rd32(a));
        end

        // reset while the load sits in MEM_RD: no write may follow
        w0 = wen_cnt; r0 = drd_cnt;
        @(negedge clk);
        drive(mk(1,1,1,1,1,1, 4'd1, 4'd9, 12'd4));
        en = 1'b1;
        @(negedge clk); en = 1'b0;       // RD_BASE
        @(negedge clk);                  // CALC
        @(negedge clk); rst_n = 1'b0;    // MEM_RD
        @(negedge clk); rst_n = 1'b1;
        chk("abort_outs_zero", {31'd0, outs_any()}, 32'd0);
        chk("abort_reached_mem_rd", 32'(drd_cnt - r0), 32'd1);
        repeat (12) @(negedge clk);
        chk("abort_no_write", 32'(wen_cnt - w0), 32'd0);
        chk("abort_r1", regs[1], exp_regs[1]);
        chk("abort_r9", regs[9], exp_regs[9]);

        // en held for two cycles starts exactly one store
        w0 = wen_cnt; d0 = dwr_cnt;
        @(negedge clk);
        drive(mk(1,1,1,1,1,0, 4'd2, 4'd4, 12'd8));
        en = 1'b1;
        @(negedge clk);
        @(negedge clk); en = 1'b0;
        repeat (14) @(negedge clk);
        model_exec(mk(1,1,1,1,1,0, 4'd2, 4'd4, 12'd8), a);
        chk("held_en_mem_writes", 32'(dwr_cnt - d0), 32'd1);
        chk("held_en_reg_writes", 32'(wen_cnt - w0), 32'd1);
        chk("held_en_rn", regs[2], exp_regs[2]);
        chk("held_en_mem", env_rd32(a), model_rd32(a));

        for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), regs[i], exp_regs[i]);
        chk("exclusive_enables", 32'(viol_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdt_unit.md
SDT_UNIT -- requirements
Module: sdt_unit

Interface
REQ-001 clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 en  in  1  start request, sampled only in IDLE; immediate, pre, up, word, write, load  in  1 each  instruction fields, latched with en.
REQ-003 rn, rd  in  4 each  base / data register; offset  in  12  offset field, latched with en.
REQ-004 write_en  out  1; write_reg  out  4; write_value  out  32; write_restore_from_SPSR  out  1 (constant 0).
REQ-005 read_en  out  1; read_reg  out  4; read_value  in  32 (register file, valid the cycle after read_en).
REQ-006 data_write_word_en, data_write_byte_en, data_read_word_en, data_read_byte_en  out  1 each.
REQ-007 data_write_word_address, data_write_byte_address, data_read_word_address, data_read_byte_address  out  32; data_write_word_data  out  32; data_write_byte_data  out  8.
REQ-008 data_read_word_data  in  32; data_read_byte_data  in  8 (memory, valid the cycle after the read enable).

Function
REQ-009 FSM: IDLE -> RD_BASE -> [RD_OFF] -> CALC -> (store: RD_DATA -> MEM_WR) | (load: MEM_RD -> MEM_WAIT) -> WB -> WR_RD -> IDLE.
REQ-010 IDLE: on en=1 latch all fields into cur_* registers; en ignored in any other state.
REQ-011 RD_BASE: read_en=1, read_reg=cur_rn; base captured next cycle.
REQ-012 immediate=1: offset value = zero-extended offset[11:0].
REQ-013 CALC: eff = up ? base+off : base-off (32-bit, wrap modulo 2^32); access address = pre ? eff : base.
REQ-014 Store: RD_DATA reads cur_rd; MEM_WR pulses data_write_word_en (word=1, data=Rd) or data_write_byte_en (word=0, data=Rd[7:0]) for one cycle.
REQ-015 Load: MEM_RD pulses data_read_word_en or data_read_byte_en one cycle; data captured in MEM_WAIT; byte loads zero-extend to 32 bits.
REQ-016 Write-back: WB pulses write_en, write_reg=cur_rn, write_value=eff when (write=1 or pre=0); otherwise no write.
REQ-017 WR_RD (load only): write_en=1, write_reg=cur_rd, loaded value; issued after WB, so rn==rd load leaves loaded value.
REQ-018 All enables single-cycle pulses, mutually exclusive, registered; addresses unaligned passed unchanged.
REQ-019 Operation completes within 12 cycles of en; register-file writes never coincide with read_en.

Reset
REQ-020 rst_n=0 at clk edge: state=IDLE, all cur_*/temporaries 0, all enables 0, addresses/data/write_value/write_reg 0.
REQ-021 Reset mid-operation aborts with no further register or memory write.

Configuration
REQ-022 SDT_REG_OFFSET_EN defined: immediate=0 selects register offset: RD_OFF reads Rm=offset[3:0], shifted by offset[11:7] per offset[6:5] (LSL, LSR, ASR, ROR; amount 0 = no shift).
REQ-023 SDT_REG_OFFSET_EN undefined: RD_OFF absent; immediate ignored, offset always the zero-extended immediate.

Structure
REQ-024 Package sdt_pkg: FSM state encoding, REG_W=4, DATA_W=32, OFF_W=12, shift-type constants.
REQ-025 One sub-module sdt_shifter (combinational barrel shift of Rm), instantiated only under SDT_REG_OFFSET_EN.

Verification
REQ-026 R1=100, R3=DEADBEEF; STR word pre up wb offset 4 -> mem[104]=DEADBEEF, R1=104.
REQ-027 Then LDR word pre, rn=R1, rd=R10, offset 0, no wb -> R10=DEADBEEF, R1 stays 104.
REQ-028 R2=200, R5=AA; STRB [R2], no wb; LDRB R11,[R2] -> R11=000000AA, R2=200.
REQ-029 R6=3000, R7=77; STRB [R6]; LDRB R8 post-index up offset 4 -> R8=00000077, R6=3004.
REQ-030 Assert rst_n=0 in MEM_RD of a load -> no write_en pulse, state IDLE, outputs 0; en held 2 cycles -> single operation only.
